// File: rtl/mpcondsub.sv
// Multi-precision conditional subtractor: result = (a >= m) ? a - m : a.
// Subtracts one LIMB-wide limb per cycle, LSB limb first, with a rippling borrow.
module mpcondsub #(
  parameter int unsigned WIDTH = 1028,
  parameter int unsigned LIMB  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-2:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             ge,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NLIMB = (WIDTH + LIMB - 1) / LIMB;
  localparam int unsigned TOT   = NLIMB * LIMB;
  localparam int unsigned DREG  = TOT - LIMB;
  localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_next;
  logic             load_c, sub_c, last_c;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_reg;
  logic [TOT-1:0]   a_sh, m_sh;
  logic [DREG-1:0]  diff_reg;
  logic [LIMB:0]    diff_ext;
  logic [TOT-1:0]   diff_full;

  // One limb of a - m - borrow; the extra top bit is the outgoing borrow.
  assign diff_ext  = {1'b0, a_sh[LIMB-1:0]} - {1'b0, m_sh[LIMB-1:0]} - (LIMB+1)'(borrow);
  // Differences enter at the top and shift down, so limb 0 ends at the bottom.
  assign diff_full = {diff_ext[LIMB-1:0], diff_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    sub_c      = 1'b0;
    last_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = S_SUB;
        end
      end
      S_SUB: begin
        sub_c = 1'b1;
        if (cnt == CW'(NLIMB - 1)) begin
          last_c     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      borrow   <= 1'b0;
      a_reg    <= '0;
      a_sh     <= '0;
      m_sh     <= '0;
      diff_reg <= '0;
      result   <= '0;
      ge       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= (state_next == S_DONE);
      if (load_c) begin
        a_reg  <= in_a;
        a_sh   <= TOT'(in_a);
        m_sh   <= TOT'(in_m);
        cnt    <= '0;
        borrow <= 1'b0;
      end else if (sub_c) begin
        a_sh     <= a_sh >> LIMB;
        m_sh     <= m_sh >> LIMB;
        diff_reg <= diff_full[TOT-1:LIMB];
        borrow   <= diff_ext[LIMB];
        cnt      <= cnt + CW'(1);
      end
      if (last_c) begin
        result <= diff_ext[LIMB] ? a_reg : diff_full[WIDTH-1:0];
        ge     <= ~diff_ext[LIMB];
      end
    end
  end

endmodule

// File: tb/tb_mpcondsub.sv
// Directed bench for mpcondsub: hand-computed results, latency, busy length,
// ignored restart, mid-operation reset and back-to-back throughput.
module tb_mpcondsub;

  localparam int unsigned W     = 1028;
  localparam int unsigned NLIMB = 17;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] in_a;
  logic [W-2:0] in_m;
  logic [W-1:0] result;
  logic         ge;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  mpcondsub #(.WIDTH(W), .LIMB(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in_a   (in_a),
    .in_m   (in_m),
    .result (result),
    .ge     (ge),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    logic [W-1:0] x;
    checks++;
    if (act !== exp) begin
      failures++;
      x = act ^ exp;
      $display("FAIL %s: got low128=%h expected low128=%h (differing bits=%0d)",
               tag, act[127:0], exp[127:0], $countones(x));
    end
  endtask

  // One operation; poke >= 0 injects a restart (or a reset) at that SUB cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-2:0] m,
                        input logic [W-1:0] exp_res, input logic exp_ge,
                        input int poke, input bit poke_rst);
    int busy_n, done_n, lat;
    @(negedge clk);
    in_a  = a;
    in_m  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a  = ~a;
    in_m  = ~m;
    busy_n = 0;
    done_n = 0;
    lat    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == poke) begin
        if (poke_rst) begin
          reset = 1'b1;
          #1;
          check({tag, " rst result"}, result, '0);
          check({tag, " rst ge"}, W'(ge), '0);
          check({tag, " rst busy"}, W'(busy), '0);
          check({tag, " rst done"}, W'(done), '0);
        end else begin
          start = 1'b1;
          in_a  = W'(1000);
          in_m  = (W-1)'(1);
        end
      end else if (i == poke + 1) begin
        reset = 1'b0;
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat == 0) lat = i + 1;
      end
    end
    if (poke_rst) begin
      check({tag, " no done"}, W'(done_n), '0);
    end else begin
      check({tag, " latency"}, W'(lat), W'(NLIMB + 1));
      check({tag, " busy cycles"}, W'(busy_n), W'(NLIMB + 1));
      check({tag, " done pulses"}, W'(done_n), W'(1));
      check({tag, " result"}, result, exp_res);
      check({tag, " ge"}, W'(ge), W'(exp_ge));
    end
  endtask

  logic [W-1:0] one, big, r;
  int first, second;

  initial begin
    one   = W'(1);
    reset = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_m  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, '0);
    check("reset ge", W'(ge), '0);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    @(negedge clk);
    reset = 1'b0;

    run_op("5-3", W'(5), (W-1)'(3), W'(2), 1'b1, -1, 1'b0);
    run_op("3-5", W'(3), (W-1)'(5), W'(3), 1'b0, -1, 1'b0);
    run_op("100-7", W'(100), (W-1)'(7), W'(93), 1'b1, -1, 1'b0);

    big = (one << 1026) - one;
    run_op("equal", big, (W-1)'(big), '0, 1'b1, -1, 1'b0);
    run_op("2^64-1", one << 64, (W-1)'(1), (one << 64) - one, 1'b1, -1, 1'b0);
    r = (one << 1026) + one;
    run_op("top bit", one << 1027, (W-1)'(r), (one << 1026) - one, 1'b1, -1, 1'b0);

    run_op("restart ignored", W'(20), (W-1)'(6), W'(14), 1'b1, 5, 1'b0);
    check("restart idle", W'(busy), '0);

    run_op("reset mid", W'(50), (W-1)'(8), '0, 1'b0, 8, 1'b1);
    check("post reset result", result, '0);
    run_op("10-4", W'(10), (W-1)'(4), W'(6), 1'b1, -1, 1'b0);

    // Start held high: operations repeat every NLIMB+2 cycles.
    @(negedge clk);
    in_a   = W'(9);
    in_m   = (W-1)'(4);
    start  = 1'b1;
    first  = -1;
    second = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    start = 1'b0;
    check("b2b period", W'(second - first), W'(NLIMB + 2));
    check("b2b result", result, W'(5));
    repeat (25) @(negedge clk);
    check("b2b idle", W'(busy), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpcondsub.md
MPCONDSUB -- requirements
Module: mpcondsub

Interface
REQ-001 SHALL have parameter WIDTH, default 1028, the width of the operand and result.
REQ-002 SHALL have parameter LIMB, default 64, the bits processed per cycle; NLIMB = ceil(WIDTH/LIMB), 17 at defaults.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port in_a  input  WIDTH  minuend: the raw sum from the multi-precision adder.
REQ-007 SHALL have port in_m  input  WIDTH-1  modulus, zero-extended to WIDTH internally.
REQ-008 SHALL have port result  output  WIDTH  reduced value, registered.
REQ-009 SHALL have port ge  output  1  registered; high when in_a >= in_m for the last completed operation.
REQ-010 SHALL have port busy  output  1  high in SUB and DONE states.
REQ-011 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, SUB and DONE, with the following transitions:
- IDLE -> SUB on start=1.
- SUB -> DONE after NLIMB SUB cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 SHALL, on the IDLE edge with start=1, perform all of the following:
- register in_a and in_m, zero-extended to NLIMB*LIMB bits;
- clear the limb counter and the borrow.
REQ-014 SHALL, in each SUB cycle i (0..NLIMB-1), compute diff_i = a_i - m_i - borrow over LIMB bits, least-significant limb first.
REQ-015 SHALL, in the same SUB cycle, store diff_i in limb i of the difference register and set borrow to 1 iff a_i < m_i + borrow.
REQ-016 SHALL, on the SUB->DONE edge, perform all of the following:
- load result with the captured a if the final borrow=1, else with the difference (low WIDTH bits);
- set ge = ~borrow.
REQ-017 SHALL assert done high for exactly the DONE cycle, NLIMB+1 cycles after the start-sampling edge (18 at defaults).
REQ-018 SHALL keep result and ge stable from DONE until the next SUB->DONE edge.
REQ-019 SHALL ignore start while in SUB or DONE: no restart, no queuing.
REQ-020 SHALL use the registered operands only, so that in_a/in_m changes after the start-sampling edge have no effect on the operation in flight.
REQ-021 SHALL give result = 0 and ge = 1 when in_a = in_m.
REQ-022 SHALL handle in_a >= 2*in_m by a single subtraction only: no iteration, result = in_a - in_m.
REQ-023 SHALL propagate the borrow across every limb boundary, including the upper limbs that are zero-padded.
REQ-024 SHALL return to IDLE when start is held high continuously, then begin a new operation on the next IDLE edge; back-to-back period NLIMB+2 cycles.

Reset
REQ-025 SHALL, while reset=1 (asynchronously, any state), force all of the following:
- state to IDLE;
- result, ge, done, busy, borrow, limb counter and operand registers to 0.
REQ-026 SHALL abort any operation interrupted by reset mid-SUB, with no done pulse; the first start after reset deasserts begins a fresh operation.

Verification
REQ-027 SHALL cover: in_a=5, in_m=3, start 1 cycle -> done on the 18th edge after the start edge, result=2, ge=1, busy high for 18 cycles.
REQ-028 SHALL cover: in_a=3, in_m=5 -> result=3, ge=0.
REQ-029 SHALL cover: in_a=in_m=2^1026-1 -> result=0, ge=1; then in_a=2^64, in_m=1 -> result=2^64-1, exercising borrow across limbs 0..1.
REQ-030 SHALL cover: in_a=2^1027 (top bit only), in_m=2^1026+1 -> result=2^1026-1, ge=1, borrow crossing all 17 limbs.
REQ-031 SHALL cover: start pulsed again 5 cycles into SUB with different operands -> ignored, first result unchanged, exactly one done pulse.
REQ-032 SHALL cover: reset pulsed 8 cycles into SUB -> all outputs 0 immediately, no done pulse; a subsequent in_a=10, in_m=4 operation -> result=6, done 18 cycles after its start edge.
